// File: rtl/ar_rxd_pkg.sv
// Shared constants, types and helpers for the ARINC-429 receiver.
// Rate constants and the Nt selection match the transmitter encoding of Nvel.
package ar_rxd_pkg;

    localparam int unsigned FCLK    = 50_000_000;
    localparam int unsigned V1MB    = 1_000_000;
    localparam int unsigned V100KB  = 100_000;
    localparam int unsigned V50KB   = 50_000;
    localparam int unsigned V12_5KB = 12_500;

    // Half bit period in clocks for each rate
    localparam int unsigned NT3 = FCLK / (2 * V1MB);
    localparam int unsigned NT2 = FCLK / (2 * V100KB);
    localparam int unsigned NT1 = FCLK / (2 * V50KB);
    localparam int unsigned NT0 = FCLK / (2 * V12_5KB);

    localparam int unsigned GAP_MAX = 3 * NT0;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADR_W   = 8;
    localparam int unsigned DAT_W   = 23;
    localparam int unsigned BIT_MAX = (1 << BIT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RX    = 2'd1,
        ST_ABORT = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } ar_word_t;

    // Idle threshold that closes a word: 1.5 bit times
    function automatic logic [GAP_W-1:0] tgap_of(input logic [1:0] nvel);
        case (nvel)
            2'd3:    tgap_of = GAP_W'(3 * NT3);
            2'd2:    tgap_of = GAP_W'(3 * NT2);
            2'd1:    tgap_of = GAP_W'(3 * NT1);
            default: tgap_of = GAP_W'(3 * NT0);
        endcase
    endfunction

    // Address arrives MSB first, data LSB first
    function automatic ar_word_t unpack_word(input logic [WORD_W-1:0] sr);
        ar_word_t w;
        for (int i = 0; i < ADR_W; i++) begin
            w.adr[ADR_W-1-i] = sr[i];
        end
        w.dat = sr[ADR_W +: DAT_W];
        return w;
    endfunction

endpackage

// File: rtl/ar_rx_filt.sv
// Line conditioner: 2-FF synchroniser followed by a 2-sample agreement filter.
// A new level appears on o_q three clocks after it reaches i_d.
module ar_rx_filt (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_q  <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            if (r_s1 == r_s2) begin
                r_q <= r_s2;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ar_rxd.sv
// ARINC-429 receiver: decodes bipolar RZ pulse pairs into 32-bit words and
// reports good words and framing/parity/line errors as one-clock strobes.
module ar_rxd
    import ar_rxd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Nvel,
    input  logic             RXD1,
    input  logic             RXD0,
    output logic [ADR_W-1:0] ADR,
    output logic [DAT_W-1:0] DAT,
    output logic             ce_wr,
    output logic             err_par,
    output logic             err_len,
    output logic             err_line,
    output logic             en_rx,
    output logic [BIT_W-1:0] cb_bit
);

    logic w_r1;
    logic w_r0;

    ar_rx_filt u_filt1 (.clk(clk), .rst_n(rst_n), .i_d(RXD1), .o_q(w_r1));
    ar_rx_filt u_filt0 (.clk(clk), .rst_n(rst_n), .i_d(RXD0), .o_q(w_r0));

    rx_state_t         r_state;
    rx_state_t         w_state_n;
    logic [GAP_W-1:0]  r_cb_gap;
    logic [GAP_W-1:0]  w_cb_gap_n;
    logic [GAP_W-1:0]  w_tgap;
    logic              r_any_d;
    logic [1:0]        r_nvel_d;
    logic [BIT_W-1:0]  r_cb_bit;
    logic [BIT_W-1:0]  w_cb_bit_n;
    logic [WORD_W-1:0] r_sr;
    logic [WORD_W-1:0] w_sr_n;
    ar_word_t          r_word;
    ar_word_t          w_word_n;
    logic              r_ce_wr,  w_ce_wr_n;
    logic              r_err_par, w_err_par_n;
    logic              r_err_len, w_err_len_n;
    logic              r_err_line, w_err_line_n;
    logic              r_en_rx,  w_en_rx_n;

    logic w_any;
    logic w_bit_ev;
    logic w_line_err;
    logic w_nvel_chg;
    logic w_cnt_clr;
    logic w_gap;

    assign w_any      = w_r1 | w_r0;
    assign w_bit_ev   = w_any & ~r_any_d;
    assign w_line_err = w_r1 & w_r0;
    assign w_nvel_chg = (Nvel != r_nvel_d);
    assign w_tgap     = tgap_of(Nvel);
    assign w_cnt_clr  = w_any | w_nvel_chg;

    // Gap fires on the clock the idle counter reaches the threshold, once per idle period
    assign w_gap = ~w_cnt_clr & (r_cb_gap == (w_tgap - GAP_W'(1)));

    always_comb begin
        w_cb_gap_n = r_cb_gap;
        if (w_cnt_clr) begin
            w_cb_gap_n = '0;
        end else if (r_cb_gap < w_tgap) begin
            w_cb_gap_n = r_cb_gap + GAP_W'(1);
        end else begin
            w_cb_gap_n = w_tgap;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_n    = r_state;
        w_cb_bit_n   = r_cb_bit;
        w_sr_n       = r_sr;
        w_word_n     = r_word;
        w_en_rx_n    = r_en_rx;
        w_ce_wr_n    = 1'b0;
        w_err_par_n  = 1'b0;
        w_err_len_n  = 1'b0;
        w_err_line_n = 1'b0;

        if (w_nvel_chg && (r_state != ST_IDLE)) begin
            w_state_n  = ST_IDLE;
            w_en_rx_n  = 1'b0;
            w_cb_bit_n = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_line_err) begin
                        w_err_line_n = 1'b1;
                        w_state_n    = ST_ABORT;
                    end else if (w_bit_ev) begin
                        w_state_n  = ST_RX;
                        w_cb_bit_n = BIT_W'(1);
                        w_sr_n     = '0;
                        w_sr_n[0]  = w_r1;
                        w_en_rx_n  = 1'b1;
                    end
                end
                ST_RX: begin
                    if (w_line_err) begin
                        w_err_line_n = 1'b1;
                        w_en_rx_n    = 1'b0;
                        w_state_n    = ST_ABORT;
                    end else if (w_gap) begin
                        w_en_rx_n = 1'b0;
                        w_state_n = ST_IDLE;
                        if (r_cb_bit != BIT_W'(WORD_W)) begin
                            w_err_len_n = 1'b1;
                        end else if (!(^r_sr)) begin
                            w_err_par_n = 1'b1;
                        end else begin
                            w_ce_wr_n = 1'b1;
                            w_word_n  = unpack_word(r_sr);
                        end
                    end else if (w_bit_ev) begin
                        if (r_cb_bit != BIT_W'(BIT_MAX)) begin
                            w_cb_bit_n = r_cb_bit + BIT_W'(1);
                        end
                        if (!r_cb_bit[BIT_W-1]) begin
                            w_sr_n[r_cb_bit[BIT_W-2:0]] = w_r1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (w_gap) begin
                        w_state_n = ST_IDLE;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cb_gap   <= '0;
            r_any_d    <= 1'b0;
            r_nvel_d   <= Nvel;
            r_cb_bit   <= '0;
            r_sr       <= '0;
            r_word     <= '0;
            r_en_rx    <= 1'b0;
            r_ce_wr    <= 1'b0;
            r_err_par  <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_line <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cb_gap   <= w_cb_gap_n;
            r_any_d    <= w_any;
            r_nvel_d   <= Nvel;
            r_cb_bit   <= w_cb_bit_n;
            r_sr       <= w_sr_n;
            r_word     <= w_word_n;
            r_en_rx    <= w_en_rx_n;
            r_ce_wr    <= w_ce_wr_n;
            r_err_par  <= w_err_par_n;
            r_err_len  <= w_err_len_n;
            r_err_line <= w_err_line_n;
        end
    end

    assign ADR      = r_word.adr;
    assign DAT      = r_word.dat;
    assign ce_wr    = r_ce_wr;
    assign err_par  = r_err_par;
    assign err_len  = r_err_len;
    assign err_line = r_err_line;
    assign en_rx    = r_en_rx;
    assign cb_bit   = r_cb_bit;

endmodule
